// File: rtl/tema3_3a_sw_led.sv
// Switch-to-LED converter: 2-flop synchronizer, per-bit debounce filter,
// and a registered binary-reflected Gray code of the filtered switches on the LEDs.
module tema3_3a_sw_led #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  output logic [3:0] led
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0] sync1_q;
  logic [3:0] sync2_q;
  logic [3:0] filt_vec;
  logic [3:0] led_q;
  logic [3:0] led_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 4'b0000;
      sync2_q <= 4'b0000;
    end else begin
      sync1_q <= sw;
      sync2_q <= sync1_q;
    end
  end

  // Each bit owns its counter, so simultaneous changes settle on the same edge.
  for (genvar gi = 0; gi < 4; gi++) begin : g_debounce
    logic          filt_q;
    logic          filt_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      if (sync2_q[gi] != filt_q) begin
        if (cnt_q == CNT_LAST) begin
          filt_d = sync2_q[gi];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        filt_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        filt_q <= filt_d;
        cnt_q  <= cnt_d;
      end
    end

    assign filt_vec[gi] = filt_q;
  end

  assign led_d = filt_vec ^ (filt_vec >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q <= 4'b0000;
    end else begin
      led_q <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_tema3_3a_sw_led.sv
// Self-checking bench for tema3_3a_sw_led: vector table plus a timed scoreboard
// of expected LED values, and hand-written glitch/bounce/reset sequences.
module tb_tema3_3a_sw_led;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] sw = 4'b1111;
  logic [3:0] led;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0] sw;
    logic [3:0] led;
    int         hold;
  } vec_t;

  typedef struct {
    logic [3:0] led;
    int         due;
    string      tag;
  } sb_t;

  sb_t sb_q[$];

  tema3_3a_sw_led #(.DEBOUNCE_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (sw),
    .led   (led)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: led=%b required %b (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [3:0] v, input int due, input string tag);
    sb_t e;
    e.led = v;
    e.due = due;
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic push_window(input logic [3:0] v, input int from, input int to,
                             input string tag);
    for (int d = from; d <= to; d++) push(v, d, tag);
  endtask

  // Scoreboard consumer: compares every entry whose due cycle has arrived.
  always @(negedge clk) begin
    sb_t e;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      e = sb_q.pop_front();
      check(e.tag, led, e.led);
    end
  end

  initial begin
    vec_t       vecs[35];
    logic [3:0] v;
    logic [3:0] prev;
    int         base;
    int         drain;

    vecs[0].sw = 4'b0101; vecs[0].led = 4'b0111; vecs[0].hold = 10;
    vecs[1].sw = 4'b1111; vecs[1].led = 4'b1000; vecs[1].hold = 10;
    vecs[2].sw = 4'b1000; vecs[2].led = 4'b1100; vecs[2].hold = 10;
    for (int i = 0; i < 32; i++) begin
      v = 4'(i);
      vecs[3 + i].sw   = v;
      vecs[3 + i].led  = v ^ (v >> 1);
      vecs[3 + i].hold = 10;
    end

    // Reset with no clock edge yet: the clear must be asynchronous.
    #3 rst_n = 1'b0;
    #1 check("rst_async", led, 4'b0000);
    repeat (3) @(negedge clk);
    check("rst_hold", led, 4'b0000);

    rst_n = 1'b1;
    prev  = 4'b0000;
    for (int i = 0; i < 35; i++) begin
      sw = vecs[i].sw;
      $display("[TB] vec %0d sw=%b expect led=%b", i, vecs[i].sw, vecs[i].led);
      push(prev, cyc + 6, "vec_before_latency");
      push(vecs[i].led, cyc + 7, "vec_settled");
      repeat (vecs[i].hold) @(negedge clk);
      prev = vecs[i].led;
    end

    sw = 4'b0000;
    $display("[TB] glitch prep sw=0000 expect led=0000");
    push(prev, cyc + 6, "glitch_prep_before");
    push(4'b0000, cyc + 7, "glitch_prep_settled");
    repeat (10) @(negedge clk);

    // Three-clock pulse on sw[2] must be filtered out entirely.
    $display("[TB] glitch 3-clock pulse on sw[2] expect led=0000");
    base = cyc;
    sw = 4'b0100;
    push_window(4'b0000, base + 1, base + 12, "glitch3_rejected");
    repeat (3) @(negedge clk);
    sw = 4'b0000;
    repeat (12) @(negedge clk);

    // Four-clock pulse just passes, then the return to 0 also debounces.
    $display("[TB] glitch 4-clock pulse on sw[2] expect led=0110 then 0000");
    base = cyc;
    sw = 4'b0100;
    push(4'b0000, base + 6, "glitch4_before");
    push_window(4'b0110, base + 7, base + 10, "glitch4_accepted");
    push(4'b0000, base + 11, "glitch4_released");
    repeat (4) @(negedge clk);
    sw = 4'b0000;
    repeat (10) @(negedge clk);

    $display("[TB] bounce sw[0] for 20 clocks then hold 1 expect led=0001");
    for (int t = 0; t < 20; t++) begin
      sw[0] = ~sw[0];
      push(4'b0000, cyc + 1, "bounce_quiet");
      @(negedge clk);
    end
    base = cyc;
    sw = 4'b0001;
    push_window(4'b0000, base + 1, base + 6, "bounce_before");
    push_window(4'b0001, base + 7, base + 9, "bounce_settled");
    repeat (10) @(negedge clk);

    // Async reset while led is non-zero, then full re-acquisition.
    $display("[TB] async reset with led=0001 then re-acquire");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("rst_nonzero_async", led, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    base = cyc;
    push_window(4'b0000, base + 1, base + 6, "reacq_before");
    push_window(4'b0001, base + 7, base + 8, "reacq_settled");
    repeat (10) @(negedge clk);

    sw = 4'b0000;
    $display("[TB] midrst prep sw=0000 expect led=0000");
    push(4'b0001, cyc + 6, "midrst_prep_before");
    push(4'b0000, cyc + 7, "midrst_prep_settled");
    repeat (10) @(negedge clk);

    $display("[TB] midrst sw=1010, reset at edge 3, expect led=1111 after release");
    sw = 4'b1010;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("midrst_async", led, 4'b0000);
    repeat (2) @(negedge clk);
    check("midrst_hold", led, 4'b0000);
    rst_n = 1'b1;
    base = cyc;
    push_window(4'b0000, base + 1, base + 6, "midrst_before");
    push_window(4'b1111, base + 7, base + 9, "midrst_settled");

    drain = 0;
    while (sb_q.size() > 0 && drain < 30) begin
      @(negedge clk);
      drain++;
    end
    while (sb_q.size() > 0) begin
      sb_t e;
      e = sb_q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL %s: timeout, entry never compared (required %b)", e.tag, e.led);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
